loop_unroll_buffer: RTL and testbench

LOOP_UNROLL_BUFFER -- requirements
Module: loop_unroll_buffer

---
 rtl/loop_unroll_buffer.sv | 208 ++++++++++++++++++++
 tb/tb_loop_unroll_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_unroll_buffer.sv
// Loop unroll buffer: captures a loop body from the 4-wide fetch stream and replays it REPLAY_CNT times.
// Optional feature macro LUB_PC_TRACK_EN stores per-slot PCs so replayed bundles carry their original PCs.
module loop_unroll_buffer #(
    parameter int DEPTH      = 64,
    parameter int REPLAY_CNT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] inst_in,
    input  logic [63:0] pc_in,
    input  logic [3:0]  inst_valid_in,
    input  logic        loop_strt_in,
    input  logic        fnsh_unrll_in,
    input  logic        mis_pred_in,
    output logic [63:0] inst_out,
    output logic [63:0] pc_out,
    output logic [3:0]  inst_valid_out,
    output logic        stll_ftch_out,
    output logic [1:0]  lub_state_out,
    output logic        buf_ovf_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        REPLAY  = 2'b10
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] wr_ptr, wr_ptr_nxt;
    logic [PW-1:0] rd_ptr, rd_ptr_nxt;
    logic [PW-1:0] body_len, body_len_nxt;
    logic [7:0]    iter, iter_nxt;
    logic          wr_en;
    logic [2:0]    n_in;
    logic [2:0]    rd_k;
    logic [PW-1:0] wr_end;
    logic [PW-1:0] rd_rem;
    logic [PW-1:0] rd_end;
    logic [63:0]   rd_inst;
    logic [63:0]   rd_pc;
    logic [63:0]   inst_nxt;
    logic [63:0]   pc_nxt;
    logic [3:0]    valid_nxt;
    logic          ovf_nxt;
    logic          stll_nxt;

    logic [15:0]   inst_mem [DEPTH];
`ifdef LUB_PC_TRACK_EN
    logic [15:0]   pc_mem [DEPTH];
`endif

    // Illegal masks collapse to their run of leading ones.
    function automatic logic [2:0] lead_ones(input logic [3:0] m);
        casez (m)
            4'b0???: lead_ones = 3'd0;
            4'b10??: lead_ones = 3'd1;
            4'b110?: lead_ones = 3'd2;
            4'b1110: lead_ones = 3'd3;
            default: lead_ones = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] slot_mask(input logic [2:0] k);
        case (k)
            3'd0:    slot_mask = 4'b0000;
            3'd1:    slot_mask = 4'b1000;
            3'd2:    slot_mask = 4'b1100;
            3'd3:    slot_mask = 4'b1110;
            default: slot_mask = 4'b1111;
        endcase
    endfunction

    assign n_in   = lead_ones(inst_valid_in);
    assign wr_end = wr_ptr + PW'(n_in);
    assign rd_rem = body_len - rd_ptr;
    assign rd_k   = (rd_rem >= PW'(4)) ? 3'd4 : rd_rem[2:0];
    assign rd_end = rd_ptr + PW'(rd_k);

    // Replay read: slots beyond the end of the body are forced to zero.
    always_comb begin
        rd_inst = '0;
        rd_pc   = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < rd_k) begin
                rd_inst[63-16*i -: 16] = inst_mem[rd_ptr[AW-1:0] + AW'(i)];
`ifdef LUB_PC_TRACK_EN
                rd_pc[63-16*i -: 16]   = pc_mem[rd_ptr[AW-1:0] + AW'(i)];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < n_in) begin
                    inst_mem[wr_ptr[AW-1:0] + AW'(i)] <= inst_in[63-16*i -: 16];
`ifdef LUB_PC_TRACK_EN
                    pc_mem[wr_ptr[AW-1:0] + AW'(i)]   <= pc_in[63-16*i -: 16];
`endif
                end
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        body_len_nxt = body_len;
        iter_nxt     = iter;
        wr_en        = 1'b0;
        ovf_nxt      = 1'b0;
        inst_nxt     = inst_in;
        pc_nxt       = pc_in;
        valid_nxt    = slot_mask(n_in);
        stll_nxt     = 1'b0;

        case (state)
            IDLE, CAPTURE: begin
                // wr_ptr is held at zero whenever the FSM sits in IDLE.
                if (state == CAPTURE || (loop_strt_in && n_in != 3'd0)) begin
                    if (wr_end > PW'(DEPTH)) begin
                        ovf_nxt    = 1'b1;
                        state_nxt  = IDLE;
                        wr_ptr_nxt = '0;
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_end;
                        state_nxt  = CAPTURE;
                        if (fnsh_unrll_in) begin
                            wr_ptr_nxt   = '0;
                            rd_ptr_nxt   = '0;
                            iter_nxt     = '0;
                            body_len_nxt = wr_end;
                            state_nxt    = (wr_end == '0) ? IDLE : REPLAY;
                        end
                    end
                end
            end
            REPLAY: begin
                inst_nxt  = rd_inst;
                pc_nxt    = rd_pc;
                valid_nxt = slot_mask(rd_k);
                if (rd_end == body_len) begin
                    rd_ptr_nxt = '0;
                    if (iter == 8'(REPLAY_CNT - 1)) begin
                        iter_nxt     = '0;
                        body_len_nxt = '0;
                        state_nxt    = IDLE;
                    end else begin
                        iter_nxt = iter + 8'd1;
                    end
                end else begin
                    rd_ptr_nxt = rd_end;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (mis_pred_in) begin
            state_nxt    = IDLE;
            wr_ptr_nxt   = '0;
            rd_ptr_nxt   = '0;
            body_len_nxt = '0;
            iter_nxt     = '0;
            wr_en        = 1'b0;
            ovf_nxt      = 1'b0;
            inst_nxt     = '0;
            pc_nxt       = '0;
            valid_nxt    = 4'b0000;
        end

        stll_nxt = (state_nxt == REPLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            body_len       <= '0;
            iter           <= '0;
            inst_out       <= '0;
            pc_out         <= '0;
            inst_valid_out <= 4'b0000;
            stll_ftch_out  <= 1'b0;
            buf_ovf_out    <= 1'b0;
        end else begin
            state          <= state_nxt;
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            body_len       <= body_len_nxt;
            iter           <= iter_nxt;
            inst_out       <= inst_nxt;
            pc_out         <= pc_nxt;
            inst_valid_out <= valid_nxt;
            stll_ftch_out  <= stll_nxt;
            buf_ovf_out    <= ovf_nxt;
        end
    end

    assign lub_state_out = state;

endmodule

// File: tb/tb_loop_unroll_buffer.sv
// Bench for loop_unroll_buffer: queue-based reference model, directed corner cases, then random traffic.
`timescale 1ns/1ps
module tb_loop_unroll_buffer;
    localparam int DEPTH = 8;
    localparam int RC    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] inst_in, pc_in;
    logic [3:0]  inst_valid_in;
    logic        loop_strt_in, fnsh_unrll_in, mis_pred_in;
    logic [63:0] inst_out, pc_out;
    logic [3:0]  inst_valid_out;
    logic        stll_ftch_out;
    logic [1:0]  lub_state_out;
    logic        buf_ovf_out;

    always #5 clk = ~clk;

    loop_unroll_buffer #(.DEPTH(DEPTH), .REPLAY_CNT(RC)) dut (
        .clk(clk), .rst(rst),
        .inst_in(inst_in), .pc_in(pc_in), .inst_valid_in(inst_valid_in),
        .loop_strt_in(loop_strt_in), .fnsh_unrll_in(fnsh_unrll_in), .mis_pred_in(mis_pred_in),
        .inst_out(inst_out), .pc_out(pc_out), .inst_valid_out(inst_valid_out),
        .stll_ftch_out(stll_ftch_out), .lub_state_out(lub_state_out), .buf_ovf_out(buf_ovf_out)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] bq_inst[$];
    logic [15:0] bq_pc[$];
    logic [63:0] rq_inst[$];
    logic [63:0] rq_pc[$];
    logic [3:0]  rq_mask[$];
    int          m_mode = 0;  // 0 idle, 1 capturing, 2 replaying
    logic [63:0] e_inst = '0, e_pc = '0;
    logic [3:0]  e_valid = '0;
    logic        e_stll = 1'b0, e_ovf = 1'b0;
    logic [1:0]  e_state = '0;
    bit          e_data = 1'b1;

    function automatic int lead(input logic [3:0] m);
        int c;
        c = 0;
        while (c < 4 && m[3-c]) c++;
        return c;
    endfunction

    function automatic logic [3:0] thermo(input int k);
        logic [3:0] r;
        r = '0;
        for (int j = 0; j < k; j++) r[3-j] = 1'b1;
        return r;
    endfunction

    task build_replay();
        int L, k;
        logic [63:0] bi, bp;
        L = bq_inst.size();
        for (int it = 0; it < RC; it++) begin
            for (int s = 0; s < L; s += 4) begin
                k  = (L - s < 4) ? L - s : 4;
                bi = '0;
                bp = '0;
                for (int j = 0; j < k; j++) begin
                    bi[63-16*j -: 16] = bq_inst[s+j];
                    bp[63-16*j -: 16] = bq_pc[s+j];
                end
`ifndef LUB_PC_TRACK_EN
                bp = '0;
`endif
                rq_inst.push_back(bi);
                rq_pc.push_back(bp);
                rq_mask.push_back(thermo(k));
            end
        end
        bq_inst.delete();
        bq_pc.delete();
    endtask

    task clear_model();
        bq_inst.delete(); bq_pc.delete();
        rq_inst.delete(); rq_pc.delete(); rq_mask.delete();
        m_mode = 0;
    endtask

    always @(posedge clk) begin : model
        int n;
        e_ovf  = 1'b0;
        e_data = 1'b1;
        if (rst) begin
            clear_model();
            e_inst = '0; e_pc = '0; e_valid = '0;
        end else if (mis_pred_in) begin
            clear_model();
            e_valid = '0;
            e_data  = 1'b0;
        end else if (m_mode == 2) begin
            e_inst  = rq_inst.pop_front();
            e_pc    = rq_pc.pop_front();
            e_valid = rq_mask.pop_front();
            if (rq_inst.size() == 0) m_mode = 0;
        end else begin
            n       = lead(inst_valid_in);
            e_inst  = inst_in;
            e_pc    = pc_in;
            e_valid = thermo(n);
            if (m_mode == 1 || (loop_strt_in && n > 0)) begin
                if (bq_inst.size() + n > DEPTH) begin
                    e_ovf = 1'b1;
                    clear_model();
                end else begin
                    for (int j = 0; j < n; j++) begin
                        bq_inst.push_back(inst_in[63-16*j -: 16]);
                        bq_pc.push_back(pc_in[63-16*j -: 16]);
                    end
                    m_mode = 1;
                    if (fnsh_unrll_in) begin
                        if (bq_inst.size() == 0) m_mode = 0;
                        else begin
                            build_replay();
                            m_mode = 2;
                        end
                    end
                end
            end
        end
        e_stll  = (m_mode == 2);
        e_state = 2'(m_mode);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("state", 64'(lub_state_out), 64'(e_state));
            chk("stall", 64'(stll_ftch_out), 64'(e_stll));
            chk("ovf",   64'(buf_ovf_out),   64'(e_ovf));
            chk("valid", 64'(inst_valid_out), 64'(e_valid));
            if (e_data) begin
                chk("inst", inst_out, e_inst);
                chk("pc",   pc_out,   e_pc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [63:0] i, input logic [63:0] p, input logic [3:0] m,
                         input logic ls, input logic fn, input logic mp);
        inst_in = i; pc_in = p; inst_valid_in = m;
        loop_strt_in = ls; fnsh_unrll_in = fn; mis_pred_in = mp;
    endtask

    task automatic idle();
        drive(64'h0, 64'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  mtab[5] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0000};
    logic [3:0]  masks[4];
    logic [63:0] insts[4];
    int          stl_cnt;
    logic [3:0]  rm;

    initial begin
        rst = 1'b1;
        idle();
        step();
        chk_on = 1'b1;
        step();
        chk("rst_state", 64'(lub_state_out), 64'd0);
        chk("rst_valid", 64'(inst_valid_out), 64'd0);
        rst = 1'b0;

        // six-instruction body, two replays
        drive(64'h1111_2222_3333_4444, 64'h0010_0011_0012_0013, 4'b1111, 1'b1, 1'b0, 1'b0); step();
        drive(64'h5555_6666_7777_8888, 64'h0014_0015_0016_0017, 4'b1100, 1'b0, 1'b1, 1'b0); step();
        chk("body6_enter", 64'(lub_state_out), 64'd2);
        stl_cnt = int'(stll_ftch_out);
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            masks[i] = inst_valid_out;
            insts[i] = inst_out;
            stl_cnt += int'(stll_ftch_out);
        end
        chk("body6_m0", 64'(masks[0]), 64'hF);
        chk("body6_m1", 64'(masks[1]), 64'hC);
        chk("body6_m2", 64'(masks[2]), 64'hF);
        chk("body6_m3", 64'(masks[3]), 64'hC);
        chk("body6_i0", insts[0], 64'h1111_2222_3333_4444);
        chk("body6_i1", insts[1], 64'h5555_6666_0000_0000);
        chk("body6_stall_cycles", 64'(stl_cnt), 64'd4);
        chk("body6_exit", 64'(lub_state_out), 64'd0);
        step();

        // start and finish in one bundle
        drive(64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 4'b1110, 1'b1, 1'b1, 1'b0); step();
        idle(); step();
        chk("one_m0", 64'(inst_valid_out), 64'hE);
        chk("one_i0", inst_out, 64'hAAAA_BBBB_CCCC_0000);
        step();
        chk("one_m1", 64'(inst_valid_out), 64'hE);
        chk("one_exit", 64'(lub_state_out), 64'd0);
        step();

        // overflow of an 8-slot buffer
        drive(64'h1, 64'h0, 4'b1111, 1'b1, 1'b0, 1'b0); step();
        drive(64'h2, 64'h0, 4'b1111, 1'b0, 1'b0, 1'b0); step();
        drive(64'h3, 64'h0, 4'b1000, 1'b0, 1'b0, 1'b0); step();
        chk("ovf_pulse", 64'(buf_ovf_out), 64'd1);
        chk("ovf_state", 64'(lub_state_out), 64'd0);
        chk("ovf_stall", 64'(stll_ftch_out), 64'd0);
        idle(); step();
        chk("ovf_single", 64'(buf_ovf_out), 64'd0);

        // misprediction during the second replay cycle
        drive(64'h1, 64'h0, 4'b1111, 1'b1, 1'b0, 1'b0); step();
        drive(64'h2, 64'h0, 4'b1100, 1'b0, 1'b1, 1'b0); step();
        idle(); step();
        chk("mp_in_replay", 64'(lub_state_out), 64'd2);
        drive(64'h0, 64'h0, 4'b0000, 1'b0, 1'b0, 1'b1); step();
        chk("mp_valid", 64'(inst_valid_out), 64'd0);
        chk("mp_stall", 64'(stll_ftch_out), 64'd0);
        chk("mp_state", 64'(lub_state_out), 64'd0);
        idle(); step();

        // reset in the middle of a capture
        drive(64'h1, 64'h1, 4'b1111, 1'b1, 1'b0, 1'b0); step();
        drive(64'h2, 64'h2, 4'b1000, 1'b0, 1'b0, 1'b0); step();
        chk("rc_capture", 64'(lub_state_out), 64'd1);
        idle(); rst = 1'b1; step();
        chk("rc_inst", inst_out, 64'h0);
        chk("rc_pc", pc_out, 64'h0);
        chk("rc_state", 64'(lub_state_out), 64'd0);
        rst = 1'b0;
        drive(64'h9999_8888_7777_6666, 64'h0, 4'b1100, 1'b1, 1'b1, 1'b0); step();
        idle(); step();
        chk("rc_slot0", inst_out, 64'h9999_8888_0000_0000);
        step(); step();

        // replayed PCs
        drive(64'hABCD_0000_1234_5678, 64'h0100_0101_0102_0103, 4'b1111, 1'b1, 1'b1, 1'b0); step();
        chk("pc_pass", pc_out, 64'h0100_0101_0102_0103);
        idle(); step();
`ifdef LUB_PC_TRACK_EN
        chk("pc_replay", pc_out, 64'h0100_0101_0102_0103);
`else
        chk("pc_replay", pc_out, 64'h0);
`endif
        step(); step();

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rm = ($urandom_range(0, 9) == 0) ? 4'($urandom) : mtab[$urandom_range(0, 4)];
            drive({$urandom, $urandom}, {$urandom, $urandom}, rm,
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 39) == 0));
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
